// File: rtl/mpsoc_onchip_mem_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, configurable read latency,
// byte-lane write collision resolution and a hardware clear engine.
module mpsoc_onchip_mem_dp #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 14,
  parameter int                READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_WORD      = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                init_start,
  output logic                init_done,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;
  localparam bit LAT2  = (READ_LATENCY == 2);

  typedef enum logic [1:0] {ST_CLEAR, ST_READY, ST_DRAIN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              init_done_q;
  logic              wait_q;

  logic [ADDR_W-1:0] addr  [2];
  logic [BE_W-1:0]   be    [2];
  logic [DATA_W-1:0] wdata [2];
  logic [1:0]        wr_acc;
  logic [1:0]        rd_acc;
  logic              in_flight;

  logic [1:0]        vld_p0;
  logic [1:0]        vld_p1;
  logic [DATA_W-1:0] data_p0 [2];
  logic [DATA_W-1:0] data_p1 [2];

  assign s1_waitrequest = wait_q | ~clken;
  assign s2_waitrequest = wait_q | ~clken;
  assign init_done      = init_done_q;

  always_comb begin
    addr[0]  = s1_address;
    addr[1]  = s2_address;
    be[0]    = s1_byteenable;
    be[1]    = s2_byteenable;
    wdata[0] = s1_writedata;
    wdata[1] = s2_writedata;
  end

  // A request with both read and write high is a write only.
  assign wr_acc = {s2_chipselect & s2_write & ~s2_waitrequest,
                   s1_chipselect & s1_write & ~s1_waitrequest};
  assign rd_acc = {s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest,
                   s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest};

  assign in_flight = (|vld_p0) | (LAT2 & (|vld_p1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
      wait_q      <= 1'b1;
    end else if (clken) begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state       <= ST_READY;
            init_done_q <= 1'b1;
            wait_q      <= 1'b0;
          end
        end
        ST_READY: begin
          if (init_start) begin
            state       <= ST_DRAIN;
            init_done_q <= 1'b0;
            wait_q      <= 1'b1;
          end else begin
            init_done_q <= 1'b1;
            wait_q      <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!in_flight) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // s2 lanes are written first so that s1 overrides any lane both ports enable.
  always_ff @(posedge clk) begin
    if (clken) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= INIT_WORD;
      end
      for (int p = 1; p >= 0; p--) begin
        if (wr_acc[p]) begin
          for (int b = 0; b < BE_W; b++) begin
            if (be[p][b]) mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
          end
        end
      end
    end
  end

  // p0: array read at the accepting edge (old data); p1: optional output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= '0;
      vld_p1 <= '0;
      for (int p = 0; p < 2; p++) begin
        data_p0[p] <= '0;
        data_p1[p] <= '0;
      end
    end else if (clken) begin
      vld_p0 <= rd_acc;
      vld_p1 <= vld_p0;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) data_p0[p] <= mem[addr[p]];
        if (vld_p0[p]) data_p1[p] <= data_p0[p];
      end
    end
  end

  assign s1_readdatavalid = (LAT2 ? vld_p1[0] : vld_p0[0]) & clken;
  assign s2_readdatavalid = (LAT2 ? vld_p1[1] : vld_p0[1]) & clken;
  assign s1_readdata      = LAT2 ? data_p1[0] : data_p0[0];
  assign s2_readdata      = LAT2 ? data_p1[1] : data_p0[1];

endmodule

// File: tb/tb_mpsoc_onchip_mem_dp.sv
// Self-checking bench for mpsoc_onchip_mem_dp: directed scenarios plus randomized
// traffic against a queue/array reference model of the memory behaviour.
module tb_mpsoc_onchip_mem_dp;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [31:0] INIT  = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        reset_n, clken, init_start, init_done;
  logic [AW-1:0] s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s1_readdatavalid, s1_waitrequest;
  logic        s2_chipselect, s2_read, s2_write, s2_readdatavalid, s2_waitrequest;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;

  mpsoc_onchip_mem_dp #(.DATA_W(32), .ADDR_W(AW), .READ_LATENCY(LAT),
                        .CLEAR_ON_RESET(1'b1), .INIT_WORD(INIT)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .init_start(init_start), .init_done(init_done),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: word array, per-port queue of pending reads stamped with the
  // enabled-cycle number at which they were accepted.
  typedef struct { logic [31:0] data; int acc; } rd_t;
  rd_t         q0[$];
  rd_t         q1[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd [2];
  bit          m_ready, m_drain;
  int          clear_left, en_cyc;

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    last_rd[0] = '0;
    last_rd[1] = '0;
    m_ready    = 1'b0;
    m_drain    = 1'b0;
    clear_left = DEPTH;
    en_cyc     = 0;
  endfunction

  function automatic void model_edge();
    bit          empty, r0, r1, w0, w1;
    logic [31:0] old0, old1;
    logic [AW-1:0] ca;
    if (!clken) return;
    empty = (q0.size() == 0) && (q1.size() == 0);
    en_cyc++;
    if (q0.size() > 0 && q0[0].acc + LAT <= en_cyc) begin last_rd[0] = q0[0].data; void'(q0.pop_front()); end
    if (q1.size() > 0 && q1[0].acc + LAT <= en_cyc) begin last_rd[1] = q1[0].data; void'(q1.pop_front()); end
    if (m_ready) begin
      w0 = s1_chipselect && s1_write;
      w1 = s2_chipselect && s2_write;
      r0 = s1_chipselect && s1_read && !s1_write;
      r1 = s2_chipselect && s2_read && !s2_write;
      old0 = ref_mem[s1_address];
      old1 = ref_mem[s2_address];
      for (int b = 0; b < 4; b++) begin
        if (w0 && s1_byteenable[b]) ref_mem[s1_address][8*b +: 8] = s1_writedata[8*b +: 8];
        if (w1 && s2_byteenable[b] && !(w0 && s1_byteenable[b] && s1_address == s2_address))
          ref_mem[s2_address][8*b +: 8] = s2_writedata[8*b +: 8];
      end
      if (r0) q0.push_back('{data: old0, acc: en_cyc});
      if (r1) q1.push_back('{data: old1, acc: en_cyc});
      if (init_start) begin m_ready = 1'b0; m_drain = 1'b1; end
    end else if (m_drain) begin
      if (empty) begin m_drain = 1'b0; clear_left = DEPTH; end
    end else begin
      ca = AW'(DEPTH - clear_left);
      ref_mem[ca] = INIT;
      clear_left--;
      if (clear_left == 0) m_ready = 1'b1;
    end
  endfunction

  function automatic bit exp_vld(int p);
    if (p == 0) return clken && q0.size() > 0 && (q0[0].acc + LAT - 1 == en_cyc);
    return clken && q1.size() > 0 && (q1[0].acc + LAT - 1 == en_cyc);
  endfunction

  function automatic logic [31:0] exp_rd(int p);
    if (p == 0) return (q0.size() > 0 && q0[0].acc + LAT - 1 == en_cyc) ? q0[0].data : last_rd[0];
    return (q1.size() > 0 && q1[0].acc + LAT - 1 == en_cyc) ? q1[0].data : last_rd[1];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic idle();
    init_start = 1'b0;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic req(int p, bit rd, bit wr, logic [AW-1:0] a, logic [3:0] be, logic [31:0] d);
    if (p == 0) begin
      s1_chipselect = rd | wr; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
    end else begin
      s2_chipselect = rd | wr; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
    end
  endtask

  task automatic test_reset();
    idle(); clken = 1'b1; reset_n = 1'b0; model_reset();
    tick(); tick();
    checks++; if ({s1_readdatavalid, s2_readdatavalid} !== 2'b00) begin errors++;
      $display("FAIL reset_valid: got %b expected 00", {s1_readdatavalid, s2_readdatavalid}); end
    checks++; if ({s1_readdata, s2_readdata} !== 64'h0) begin errors++;
      $display("FAIL reset_readdata: got %h expected 0", {s1_readdata, s2_readdata}); end
    checks++; if ({s1_waitrequest, s2_waitrequest} !== 2'b11) begin errors++;
      $display("FAIL reset_wait: got %b expected 11", {s1_waitrequest, s2_waitrequest}); end
    checks++; if (init_done !== 1'b0) begin errors++;
      $display("FAIL reset_init_done: got %b expected 0", init_done); end
    reset_n = 1'b1;
  endtask

  task automatic test_clear_on_reset();
    int n = 0;
    for (int i = 0; i < 40 && init_done !== 1'b1; i++) begin
      checks++; if (s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin errors++;
        $display("FAIL t1_wait_during_clear: got %b%b expected 11", s1_waitrequest, s2_waitrequest); end
      tick(); n++;
    end
    checks++; if (n !== DEPTH) begin errors++;
      $display("FAIL t1_clear_cycles: got %0d expected %0d", n, DEPTH); end
    req(0, 1'b1, 1'b0, 4'd5, 4'h0, 32'h0); tick(); idle();
    repeat (LAT - 1) begin
      checks++; if (s1_readdatavalid !== 1'b0) begin errors++;
        $display("FAIL t1_early_valid: got %b expected 0", s1_readdatavalid); end
      tick();
    end
    checks++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== INIT) begin errors++;
      $display("FAIL t1_read_init: got v=%b d=%h expected v=1 d=%h", s1_readdatavalid, s1_readdata, INIT); end
    tick();
  endtask

  task automatic test_write_read_latency();
    req(0, 1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF); tick(); idle();
    req(1, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0); tick(); idle();
    repeat (LAT - 1) begin
      checks++; if (s2_readdatavalid !== 1'b0) begin errors++;
        $display("FAIL t2_early_valid: got %b expected 0", s2_readdatavalid); end
      tick();
    end
    checks++; if (s2_readdatavalid !== 1'b1 || s2_readdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL t2_latency_read: got v=%b d=%h expected v=1 d=deadbeef", s2_readdatavalid, s2_readdata); end
    tick();
    checks++; if (s2_readdatavalid !== 1'b0 || s2_readdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL t2_hold: got v=%b d=%h expected v=0 d=deadbeef", s2_readdatavalid, s2_readdata); end
  endtask

  task automatic test_collision();
    req(0, 1'b0, 1'b1, 4'd7, 4'h3, 32'h11111111);
    req(1, 1'b0, 1'b1, 4'd7, 4'hF, 32'h22222222); tick(); idle();
    req(0, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0); tick(); idle();
    repeat (LAT - 1) tick();
    checks++; if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h22221111) begin errors++;
      $display("FAIL t3_collision: got v=%b d=%h expected v=1 d=22221111", s1_readdatavalid, s1_readdata); end
    tick();
  endtask

  task automatic test_mixed_port_old_data();
    logic [31:0] got[$];
    req(1, 1'b0, 1'b1, 4'd9, 4'hF, 32'hAAAA5555);
    req(0, 1'b1, 1'b0, 4'd9, 4'h0, 32'h0); tick(); idle();
    req(0, 1'b1, 1'b0, 4'd9, 4'h0, 32'h0); tick(); idle();
    for (int i = 0; i < 6; i++) begin
      if (s1_readdatavalid === 1'b1) got.push_back(s1_readdata);
      tick();
    end
    checks++; if (got.size() !== 2) begin errors++;
      $display("FAIL t4_strobe_count: got %0d expected 2", got.size()); end
    else begin
      checks++; if (got[0] !== INIT || got[1] !== 32'hAAAA5555) begin errors++;
        $display("FAIL t4_old_then_new: got %h,%h expected %h,aaaa5555", got[0], got[1], INIT); end
    end
  endtask

  task automatic test_back_to_back_clken();
    logic [AW-1:0] addrs [4];
    logic [31:0]   want  [4];
    logic [31:0]   got[$];
    int idx = 0;
    addrs[0] = 4'd3; addrs[1] = 4'd7; addrs[2] = 4'd9; addrs[3] = 4'd5;
    want[0] = 32'hDEADBEEF; want[1] = 32'h22221111; want[2] = 32'hAAAA5555; want[3] = INIT;
    for (int c = 0; c < 14; c++) begin
      clken = !(c >= 2 && c <= 4);
      if (idx < 4) req(0, 1'b1, 1'b0, addrs[idx], 4'h0, 32'h0); else idle();
      #1;
      if (!clken) begin
        checks++; if (s1_readdatavalid !== 1'b0) begin errors++;
          $display("FAIL t5_valid_while_frozen: got %b expected 0 (cycle %0d)", s1_readdatavalid, c); end
      end
      checks++; if (s1_readdatavalid !== exp_vld(0) || s1_readdata !== exp_rd(0)) begin errors++;
        $display("FAIL t5_model: got v=%b d=%h expected v=%b d=%h", s1_readdatavalid, s1_readdata, exp_vld(0), exp_rd(0)); end
      if (s1_readdatavalid === 1'b1) got.push_back(s1_readdata);
      if (idx < 4 && s1_waitrequest === 1'b0) idx++;
      tick();
    end
    clken = 1'b1; idle();
    checks++; if (got.size() !== 4) begin errors++;
      $display("FAIL t5_strobe_count: got %0d expected 4", got.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== want[i]) begin errors++;
        $display("FAIL t5_order[%0d]: got %h expected %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_init_start_drain();
    logic [31:0] got[$];
    int n = 0;
    clken = 1'b1;
    req(0, 1'b1, 1'b0, 4'd3, 4'h0, 32'h0); tick();
    req(0, 1'b1, 1'b0, 4'd7, 4'h0, 32'h0); init_start = 1'b1; tick(); idle();
    while (init_done !== 1'b1 && n < 100) begin
      checks++; if (s1_readdatavalid !== exp_vld(0) || s1_waitrequest !== 1'b1) begin errors++;
        $display("FAIL t6_drain: got v=%b w=%b expected v=%b w=1", s1_readdatavalid, s1_waitrequest, exp_vld(0)); end
      if (s1_readdatavalid === 1'b1) got.push_back(s1_readdata);
      tick(); n++;
    end
    checks++; if (init_done !== 1'b1 || got.size() !== 2) begin errors++;
      $display("FAIL t6_complete: got done=%b strobes=%0d expected done=1 strobes=2", init_done, got.size()); end
    else begin
      checks++; if (got[0] !== 32'hDEADBEEF || got[1] !== 32'h22221111) begin errors++;
        $display("FAIL t6_inflight_data: got %h,%h expected deadbeef,22221111", got[0], got[1]); end
    end
    got.delete();
    for (int c = 0; c < DEPTH + 6; c++) begin
      if (c < DEPTH) req(1, 1'b1, 1'b0, AW'(c), 4'h0, 32'h0); else idle();
      if (s2_readdatavalid === 1'b1) got.push_back(s2_readdata);
      tick();
    end
    checks++; if (got.size() !== DEPTH) begin errors++;
      $display("FAIL t6_scan_count: got %0d expected %0d", got.size(), DEPTH); end
    foreach (got[i]) begin
      checks++; if (got[i] !== INIT) begin errors++;
        $display("FAIL t6_cleared[%0d]: got %h expected %h", i, got[i], INIT); end
    end
  endtask

  task automatic test_reset_mid_read();
    int n = 0;
    int strobes = 0;
    req(0, 1'b1, 1'b0, 4'd2, 4'h0, 32'h0); tick(); idle();
    reset_n = 1'b0; model_reset(); #1;
    checks++; if (s1_readdatavalid !== 1'b0 || s1_readdata !== 32'h0 || s1_waitrequest !== 1'b1 || init_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_read: got v=%b d=%h w=%b done=%b expected 0 0 1 0",
                         s1_readdatavalid, s1_readdata, s1_waitrequest, init_done); end
    tick(); tick();
    reset_n = 1'b1;
    while (init_done !== 1'b1 && n < 40) begin
      if (s1_readdatavalid === 1'b1) strobes++;
      tick(); n++;
    end
    checks++; if (n !== DEPTH || strobes !== 0) begin errors++;
      $display("FAIL reset_restart_clear: got cycles=%0d strobes=%0d expected %0d and 0", n, strobes, DEPTH); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      clken = ($urandom_range(0, 9) != 0);
      init_start = ($urandom_range(0, 59) == 0);
      req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), $urandom);
      req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) s1_chipselect = 1'b0;
      #1;
      checks++; if ({s1_waitrequest, s2_waitrequest, init_done} !== {{2{!m_ready || !clken}}, m_ready}) begin errors++;
        $display("FAIL rnd_ctrl: got w=%b%b done=%b expected w=%b done=%b", s1_waitrequest, s2_waitrequest,
                 init_done, !m_ready || !clken, m_ready); end
      tick();
      checks++; if ({s1_readdatavalid, s1_readdata, s2_readdatavalid, s2_readdata} !==
                    {exp_vld(0), exp_rd(0), exp_vld(1), exp_rd(1)}) begin errors++;
        $display("FAIL rnd_read: got %b %h %b %h expected %b %h %b %h", s1_readdatavalid, s1_readdata,
                 s2_readdatavalid, s2_readdata, exp_vld(0), exp_rd(0), exp_vld(1), exp_rd(1)); end
    end
    idle(); clken = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clken = 1'b1;
    idle();
    test_reset();
    test_clear_on_reset();
    test_write_read_latency();
    test_collision();
    test_mixed_port_old_data();
    test_back_to_back_clken();
    test_init_start_drain();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
